// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler
//   Round-robin scheduler sharing one 4:1 single-bit mux channel between four
//   requesters. Every output is registered. Each owner holds the channel for
//   at most MAX_BURST consecutive cycles.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   en        : 0 blocks new grants; an ongoing burst runs to its release
//   req[3:0]  : level requests, one per requester
//   grant[3:0]: one-hot grant, all-zero when idle
//   select[1:0]: mux select code (index of owner), held while idle
//   valid     : channel owned, equals |grant
//   burst_cnt : cycles granted so far in the current burst, 0 when idle
//
// State table
//   state | meaning
//   IDLE  | no owner; grant=0, valid=0, burst_cnt=0, select holds
//   BUSY  | owner = select_q; burst_cnt counts its cycles up to MAX_BURST

module mux_rr_scheduler #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       req,
    output logic [3:0]       grant,
    output logic [1:0]       select,
    output logic             valid,
    output logic [CNT_W-1:0] burst_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       select_q, select_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;

    logic [1:0]       base;
    logic [1:0]       winner;
    logic             release_now;

    // Scan base+1, base+2, base+3, base (mod 4); first requester found wins.
    // The base itself comes last, so the previous owner only wins when alone.
    function automatic logic [1:0] pick(input logic [1:0] b, input logic [3:0] r);
        logic [1:0] idx;
        logic       found;
        pick  = b;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = b + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    // In BUSY the owner about to release becomes the new round-robin base.
    assign base        = (state_q == BUSY) ? select_q : last_q;
    assign winner      = pick(base, req);
    assign release_now = !req[select_q] || (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        last_d   = last_q;

        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    grant_d  = 4'b0001 << winner;
                    select_d = winner;
                    valid_d  = 1'b1;
                    cnt_d    = CNT_ONE;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (!release_now) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    last_d = select_q;
                    if (en && (|req)) begin
                        // zero-bubble handoff, possibly back to the same owner
                        grant_d  = 4'b0001 << winner;
                        select_d = winner;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                    end else begin
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                grant_d = 4'b0000;
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            select_q <= 2'b00;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            last_q   <= 2'd3;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    assign grant     = grant_q;
    assign select    = select_q;
    assign valid     = valid_q;
    assign burst_cnt = cnt_q;

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares one 4:1 single-bit mux channel between four requesters.
- Arbitrates among req[3:0] and drives the mux select code plus a one-hot grant.
- Bounds each owner's tenure to MAX_BURST cycles.
- Sits directly in front of the 4:1 mux. select feeds the mux select input; grant and valid go back to the requesters.

Parameters:
- MAX_BURST, 8: max consecutive cycles one requester may hold the channel; legal range 1..255.
- CNT_W, 8: width of burst_cnt; must hold MAX_BURST.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: when 0, no new grant is issued; the current burst is unaffected.
- req, input, 4: per-requester request; level, held high while data is wanted.
- grant, output, 4: one-hot grant, registered; all-zero when idle.
- select, output, 2: mux select code; binary index of the granted requester, registered.
- valid, output, 1: high when the channel is owned; equals |grant.
- burst_cnt, output, CNT_W: cycles granted so far in the current burst (1..MAX_BURST); 0 when idle.

Behaviour:
- All outputs and state are registered. No combinational path from req to any output.
- Reset (rst_n low, asynchronous):
  - grant=0, select=2'b00, valid=0, burst_cnt=0.
  - State IDLE; internal last-owner pointer last=3, so requester 0 has first priority after reset.
  - Reset asserted mid-burst aborts the burst immediately.
  - First possible grant is the first clk edge after rst_n deasserts.
- Pick function: scan indices (last+1), (last+2), (last+3), last, each mod 4. The first with req high wins. The previous owner is therefore eligible only when no other requester is waiting.
- State IDLE:
  - If en=1 and |req=1 at a clk edge: grant/select load the winner, valid=1, burst_cnt=1, state BUSY.
  - Latency is exactly 1 cycle from req sampled high to grant visible.
  - Otherwise all outputs hold their idle values. select keeps its last value, so the mux output stays stable.
- State BUSY, owner o, sampled at each edge:
  - Release condition: req[o]=0, or burst_cnt==MAX_BURST.
  - No release: grant/select hold, burst_cnt+1.
  - Release: last=o. If en=1 and |req=1, grant the pick winner in the same edge (zero-bubble handoff), burst_cnt=1, stay BUSY. Otherwise grant=0, valid=0, burst_cnt=0, state IDLE, select holds.
  - Simultaneous req[o] drop and cap expiry: one release, no double counting.
- en=0 during BUSY: the current owner continues until release, then the block goes IDLE. en has no effect on an ongoing burst.
- MAX_BURST=1: grant rotates every cycle among active requesters. A single active requester is re-granted every cycle with no bubble, burst_cnt stays 1.
- The granted requester must not change except at a release edge; grant is never multi-hot.
- Requests dropping for non-owners between edges are ignored (level-sampled only at edges).
- burst_cnt never exceeds MAX_BURST and never wraps.

Test Plan:
- Reset then idle: rst_n low 3 cycles, req=0 → grant=0, select=00, valid=0, burst_cnt=0. Assert rst_n low mid-burst → all outputs 0 asynchronously, before the next edge.
- Single requester: req=4'b0100 held 3 cycles then dropped, MAX_BURST=8 → from edge 1 grant=0100, select=10, burst_cnt=1,2,3. Edge after req[2] drops: valid=0, select stays 10.
- Burst cap and fairness: req=4'b1111 held, MAX_BURST=2 → grant order 0001,0001,0010,0010,0100,0100,1000,1000,0001…, no idle cycle, select 00,00,01,01,10,10,11,11.
- Round-robin skip: after owner 1 releases with req=4'b0011 → next grant=0001 (wraps past 2,3). With req=4'b1010 → next grant=1000.
- en gating: en=0 and req=4'b0001 → no grant. en=0 during an owner-2 burst → burst completes to the MAX_BURST cap, then IDLE despite other reqs. en=1 → grant on the next edge.
- Simultaneous drop and cap: MAX_BURST=3, owner drops req exactly at burst_cnt=3 while req[3]=1 → single handoff to requester 3 with burst_cnt=1; grant never all-zero in between.
